// File: rtl/fetch_prefetch_queue.sv
// Fetch PC owner and prefetch FIFO feeding IF/ID through a valid/ready handshake.
// Define FPQ_BYPASS_EN for a zero-latency response path into an empty queue.
module fetch_prefetch_queue #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        INST_W   = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int unsigned        PC_INC   = 4
) (
  input  logic                       Clk,
  input  logic                       Rst,
  output logic                       req_valid,
  input  logic                       req_ready,
  output logic [ADDR_W-1:0]          req_addr,
  input  logic                       rsp_valid,
  input  logic [INST_W-1:0]          rsp_data,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [INST_W-1:0]          inst,
  output logic [ADDR_W-1:0]          inst_pc,
  output logic [ADDR_W-1:0]          inst_pc_next,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  logic [ADDR_W-1:0] pc;
  logic [CW-1:0]     occ;
  logic [CW-1:0]     outst;
  logic [CW-1:0]     disc;
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic [AW-1:0]     pwp;
  logic [AW-1:0]     prp;

  logic [INST_W-1:0] q_inst [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [ADDR_W-1:0] p_pc   [DEPTH];

  logic [CW:0]       load;
  logic              credit;
  logic              hs;
  logic              rsp_ok;
  logic              keep;
  logic              byp;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] rsp_pc;

  // Credits count queued entries plus in-flight requests, so a response always fits.
  assign load      = {1'b0, occ} + {1'b0, outst};
  assign credit    = load < DEPTH_C;
  assign req_valid = !Rst && !redirect && credit;
  assign req_addr  = pc;
  assign hs        = req_valid && req_ready;

  assign rsp_ok = rsp_valid && (outst != '0);
  assign keep   = rsp_ok && (disc == '0) && !redirect;
  assign rsp_pc = p_pc[prp];

`ifdef FPQ_BYPASS_EN
  assign byp = keep && (occ == '0);
`else
  assign byp = 1'b0;
`endif

  assign inst_valid   = !redirect && ((occ != '0) || byp);
  assign inst         = byp ? rsp_data : q_inst[rp];
  assign inst_pc      = byp ? rsp_pc : q_pc[rp];
  assign inst_pc_next = inst_valid ? inst_pc + INC : '0;
  assign occupancy    = occ;

  assign pop  = inst_valid && inst_ready && !byp;
  assign push = keep && !(byp && inst_ready);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pc    <= RESET_PC;
      occ   <= '0;
      outst <= '0;
      disc  <= '0;
      wp    <= '0;
      rp    <= '0;
      pwp   <= '0;
      prp   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
        p_pc[i]   <= '0;
      end
    end else begin
      outst <= outst + CW'(hs) - CW'(rsp_ok);
      if (hs) begin
        p_pc[pwp] <= pc;
        pwp       <= pwp + 1'b1;
      end
      // The request-PC FIFO advances on every response, dropped or kept.
      if (rsp_ok)
        prp <= prp + 1'b1;
      if (redirect) begin
        pc   <= redirect_pc;
        occ  <= '0;
        wp   <= '0;
        rp   <= '0;
        disc <= outst - CW'(rsp_ok);
      end else begin
        if (hs)
          pc <= pc + INC;
        if (rsp_ok && (disc != '0))
          disc <= disc - 1'b1;
        if (push) begin
          q_inst[wp] <= rsp_data;
          q_pc[wp]   <= rsp_pc;
          wp         <= wp + 1'b1;
        end
        if (pop)
          rp <= rp + 1'b1;
        occ <= occ + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Scoreboard bench for fetch_prefetch_queue with a variable-latency in-order memory.
// Expected delivery timings assume the default build unless FPQ_BYPASS_EN is set.
module tb_fetch_prefetch_queue;

  localparam logic [31:0] K = 32'h5A5A_0F0F;
`ifdef FPQ_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        mem_v;
  logic        spur;
  logic [31:0] rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_next;
  logic [2:0]  occupancy;

  assign rsp_valid = mem_v | spur;

  fetch_prefetch_queue dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_pc_next (inst_pc_next),
    .occupancy    (occupancy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] exp_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int n_req = 0;
  int n_del = 0;
  int cyc = 0;
  int lat = 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // In-order memory: accepted request in cycle c answers in cycle c+lat.
  initial begin
    mem_v = 1'b0;
    rsp_data = '0;
    forever begin
      @(negedge Clk);
      if (Rst) mq.delete();
      else if (req_valid && req_ready) begin
        mq.push_back('{req_addr, cyc + lat});
        n_req++;
      end
      @(posedge Clk);
      cyc++;
      #1;
      mem_v = 1'b0;
      if (mq.size() > 0 && mq[0].due == cyc) begin
        mem_v = 1'b1;
        rsp_data = mq[0].addr ^ K;
        void'(mq.pop_front());
      end
    end
  end

  // Monitor: every delivered instruction must match the next expected PC.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge Clk);
      if (!Rst && inst_valid && inst_ready) begin
        n_del++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL stray_inst: got pc %h want none", inst_pc);
        end else begin
          e = exp_q.pop_front();
          chk("inst_pc", inst_pc, e);
          chk("inst", inst, e ^ K);
          chk("inst_pc_next", inst_pc_next, e + 32'd4);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    Rst = 1'b1;
    req_ready = 1'b1;
    inst_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    spur = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_inst_pc_next", inst_pc_next, 0);

    tick();
    Rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("fill_req_valid", req_valid, 1);
      chk("fill_req_addr", req_addr, 32'(4 * i));
      tick();
    end
    @(negedge Clk);
    chk("stall_req_valid", req_valid, 0);
    tick();
    @(negedge Clk);
    chk("full_occupancy", occupancy, 4);
    chk("full_req_valid", req_valid, 0);
    tick();
    chk("fill_req_count", n_req, 4);
    inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) exp_q.push_back(32'(4 * i));
    @(negedge Clk);
    chk("credit_lag", req_valid, 0);
    tick();
    @(negedge Clk);
    chk("resume_valid", req_valid, 1);
    chk("resume_addr", req_addr, 32'h10);
    repeat (9) tick();
    chk("throughput", n_del, 10);

    redirect = 1'b1;
    redirect_pc = 32'h200;
    @(negedge Clk);
    chk("redir_req_valid", req_valid, 0);
    chk("redir_inst_valid", inst_valid, 0);
    tick();
    redirect = 1'b0;
    lat = 3;
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    exp_q.push_back(32'h208);
    @(negedge Clk);
    chk("redir_next_addr", req_addr, 32'h200);
    chk("redir_flush_occ", occupancy, 0);
    repeat (7) tick();

    redirect = 1'b1;
    redirect_pc = 32'h100;
    @(negedge Clk);
    chk("lat3_redir_req_valid", req_valid, 0);
    chk("lat3_redir_inst_valid", inst_valid, 0);
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_back(32'h100 + 32'(4 * i));
    @(negedge Clk);
    chk("lat3_req_valid", req_valid, 1);
    chk("lat3_req_addr", req_addr, 32'h100);
    repeat (6) tick();
    req_ready = 1'b0;
    repeat (8) tick();
    chk("lat3_delivered", n_del, 18);
    @(negedge Clk);
    chk("drain_occupancy", occupancy, 0);

    tick();
    spur = 1'b1;
    tick();
    spur = 1'b0;
    @(negedge Clk);
    chk("spur_occupancy", occupancy, 0);
    chk("spur_inst_valid", inst_valid, 0);
    tick();

    lat = 1;
    req_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    tick();
    redirect = 1'b0;
    @(negedge Clk);
    chk("wrap_addr0", req_addr, 32'hFFFF_FFF8);
    tick();
    @(negedge Clk);
    chk("wrap_addr1", req_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge Clk);
    chk("wrap_req_valid", req_valid, 1);
    chk("wrap_addr2", req_addr, 32'h0);
    tick();
    @(negedge Clk);
    chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_pc_next", inst_pc_next, 32'h0);
    tick();
    req_ready = 1'b0;
    repeat (6) tick();

    req_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h300;
    exp_q.push_back(32'h300);
    tick();
    redirect = 1'b0;
    tick();
    req_ready = 1'b0;
    @(negedge Clk);
    chk("lat_rsp_cycle", inst_valid, BYP);
    tick();
    @(negedge Clk);
    chk("lat_next_cycle", inst_valid, !BYP);
    repeat (3) tick();
    chk("total_delivered", n_del, 23);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
